mmio_bus_bridge: RTL and testbench
==================================

# mmio_bus_bridge

Parametrised, multi-slave successor to the processor's I/O bridge. It sits between the CPU memory port and up to N_SLV memory-mapped slaves, such as the MMIO subsystem or a future video or DMA unit. It decodes the I/O address window and registers each request. It holds the CPU with a busy flag until the selected slave raises ready, so slaves may insert wait states. It returns read data with a one-cycle done pulse and reports unmapped or timed-out accesses as bus errors.

## Interface
Parameters:
- BRG_BASE, 32'hC000_0000: I/O window; a hit requires addr[31:24] == BRG_BASE[31:24].
- N_SLV, 4: number of slave channels, 1..16.
- SEL_W, 4: slave-select field width, taken from addr[23 -: SEL_W]; requires 2^SEL_W ≥ N_SLV.
- SLV_AW, 21: word-address width to slaves, taken from addr[SLV_AW+1:2].
- TIMEOUT, 255: maximum wait cycles before an error (BRIDGE_TIMEOUT_EN builds only).
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on an error.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- io_addr  in  32  CPU byte address.
- io_rd_strobe  in  1  one-cycle read request.
- io_wr_strobe  in  1  one-cycle write request.
- io_wdata  in  32  write data.
- io_wmask  in  4  byte enables.
- io_rdata  out  32  read data; valid while io_done=1.
- io_done  out  1  one-cycle completion pulse.
- io_busy  out  1  transaction in flight; the CPU stalls while high.
- io_err  out  1  one-cycle pulse, coincident with io_done, on error.
- s_cs  out  N_SLV  one-hot slave select.
- s_rd  out  1  read qualifier.
- s_wr  out  1  write qualifier.
- s_addr  out  SLV_AW  word address to the slave.
- s_wdata  out  32  write data to the slave.
- s_wmask  out  4  byte enables to the slave.
- s_rdata  in  N_SLV*32  per-slave read data, packed with slave i at [32i+31:32i].
- s_ready  in  N_SLV  per-slave completion.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: accepts a strobe only when the window hits.
  - On acceptance, registers addr fields, wdata, wmask and direction, then goes to REQ.
  - If rd and wr strobe together, the write wins and the read is dropped.
  - Strobes that miss the window are ignored.
- Decode happens in IDLE on the raw strobe cycle.
  - Select index ≥ N_SLV is unmapped: go to RESP with error set. No s_cs is driven.
- REQ (exactly one cycle):
  - Drive s_cs[sel], s_rd/s_wr, s_addr, s_wdata, s_wmask.
  - If s_ready[sel]=1 in this cycle, capture s_rdata[sel] and go to RESP; otherwise go to WAIT.
- WAIT:
  - Hold s_cs and s_rd/s_wr asserted and all s_* lines stable.
  - Go to RESP on s_ready[sel], capturing the read data.
- RESP (one cycle):
  - io_done=1.
  - io_rdata = captured data on a read, ERR_RDATA on an error read, 0 on a write.
  - io_err = error flag.
  - Next state is IDLE.
- io_busy is 1 in REQ, WAIT and RESP.
- Strobes arriving while busy are dropped; the CPU must not issue them.
- s_ready of unselected slaves is ignored. s_rdata of unselected slaves never reaches io_rdata.

## Timing
- Reset behaviour:
  - resetn=0 at a rising edge forces IDLE.
  - All outputs are 0; io_rdata is 32'h0.
  - The timeout counter is 0.
- Reset mid-transaction aborts the transaction: no done, no err, s_cs drops the next cycle.
- Latency from strobe (cycle 0) to io_done:
  - Zero-wait slave: cycle 2. REQ is cycle 1; the slave raises ready there.
  - Slave with k wait cycles: cycle 2+k.
  - Unmapped select: cycle 1.
- Back-to-back: a new strobe is accepted in the cycle after RESP, i.e. in IDLE.
- All outputs are registered or decoded from the state register only. There is no combinational path from the s_* inputs to the io_* outputs.

## Configuration
- BRIDGE_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entering REQ and increments in REQ and WAIT.
  - When the count reaches TIMEOUT without ready, the FSM goes to RESP with an error and drops s_cs.
  - A ready arriving in the same cycle as the timeout takes priority: success, no error.
- BRIDGE_TIMEOUT_EN undefined: no counter is built, WAIT holds indefinitely, and io_err fires only for unmapped selects.

## Structure
- Package mmio_bus_pkg holds:
  - the state enum;
  - the BRG_BASE default;
  - the ERR_RDATA default;
  - the slave-index localparams: SLV_MMIO=0, SLV_VIDEO=1.
- One sub-module, mmio_addr_decode, is combinational. It produces the window hit, the select index, the unmapped flag and s_addr from io_addr.
- The FSM, capture registers and timeout counter live in the top module.

## Test plan
- Zero-wait read: rd strobe at 32'hC000_0010 with slave 0, ready tied high, rdata 32'h1234_5678.
  - Expect s_cs=4'b0001 for 1 cycle with s_addr=4.
  - Expect io_done at cycle 2 with io_rdata=32'h1234_5678 and io_err=0.
- Wait-state write: wr strobe to 32'hC010_0008 with slave 1, wmask 4'b0011, ready after 3 cycles.
  - Expect s_cs[1], s_wr, s_wdata and s_wmask stable for 4 cycles.
  - Expect io_done at cycle 5 with io_rdata=0.
- Unmapped select: N_SLV=2, rd at 32'hC030_0000.
  - Expect no s_cs, and io_done+io_err at cycle 1 with io_rdata=32'hDEAD_BEEF.
- Timeout (macro on, TIMEOUT=8): slave never ready.
  - Expect io_err+io_done after 8 REQ/WAIT cycles and s_cs deasserted.
  - Ready on the 8th cycle instead: expect success.
- Window miss and robustness: rd at 32'h0000_0040 produces no activity.
  - Simultaneous rd+wr strobe is performed as a write.
  - A strobe while busy is dropped.
- Reset during WAIT: assert resetn=0 for 1 cycle.
  - Expect all outputs 0 next cycle and no io_done.
  - A new read then completes normally.

Source files
------------

// File: rtl/mmio_bus_pkg.sv
// Shared types and defaults for the MMIO bus bridge.
// Optional feature macro: BRIDGE_TIMEOUT_EN (wait-state timeout).
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [31:0] BRG_BASE_DEF  = 32'hC000_0000;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  localparam int unsigned SLV_MMIO  = 0;
  localparam int unsigned SLV_VIDEO = 1;

  // Timeout counter width, clamped to 8..16 bits.
  function automatic int tmo_cnt_w(input int unsigned t);
    int w;
    w = $clog2(t + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational I/O window decode for the MMIO bus bridge.
// Produces window hit, slave select, unmapped flag and slave word address.
module mmio_addr_decode #(
  parameter logic [31:0] BRG_BASE = 32'hC000_0000,
  parameter int unsigned N_SLV    = 4,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned SLV_AW   = 21
) (
  input  logic [31:0]       i_addr,
  output logic              o_hit,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_unmapped,
  output logic [SLV_AW-1:0] o_saddr
);

  logic w_unused;

  assign o_hit      = (i_addr[31:24] == BRG_BASE[31:24]);
  assign o_sel      = i_addr[23 -: SEL_W];
  assign o_unmapped = (32'(o_sel) >= N_SLV);
  assign o_saddr    = i_addr[SLV_AW+1:2];
  assign w_unused   = ^i_addr;

endmodule

// File: rtl/mmio_bus_bridge.sv
// CPU-to-multi-slave MMIO bridge with wait states and bus errors.
// Define BRIDGE_TIMEOUT_EN to build the wait-state timeout counter.
module mmio_bus_bridge
  import mmio_bus_pkg::*;
#(
  parameter logic [31:0] BRG_BASE  = BRG_BASE_DEF,
  parameter int unsigned N_SLV     = 4,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned SLV_AW    = 21,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           io_addr,
  input  logic                  io_rd_strobe,
  input  logic                  io_wr_strobe,
  input  logic [31:0]           io_wdata,
  input  logic [3:0]            io_wmask,
  output logic [31:0]           io_rdata,
  output logic                  io_done,
  output logic                  io_busy,
  output logic                  io_err,
  output logic [N_SLV-1:0]      s_cs,
  output logic                  s_rd,
  output logic                  s_wr,
  output logic [SLV_AW-1:0]     s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wmask,
  input  logic [N_SLV*32-1:0]   s_rdata,
  input  logic [N_SLV-1:0]      s_ready
);

  state_e              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [SLV_AW-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic [3:0]          r_wmask;
  logic                r_wr;
  logic                r_err;

  logic                w_hit;
  logic [SEL_W-1:0]    w_sel;
  logic                w_unmapped;
  logic [SLV_AW-1:0]   w_saddr;
  logic                w_strobe;
  logic                w_act;
  logic                w_rdy;
  logic [31:0]         w_sdata;
  logic                w_to;

  mmio_addr_decode #(
    .BRG_BASE (BRG_BASE),
    .N_SLV    (N_SLV),
    .SEL_W    (SEL_W),
    .SLV_AW   (SLV_AW)
  ) u_dec (
    .i_addr     (io_addr),
    .o_hit      (w_hit),
    .o_sel      (w_sel),
    .o_unmapped (w_unmapped),
    .o_saddr    (w_saddr)
  );

  assign w_strobe = io_rd_strobe | io_wr_strobe;
  assign w_act    = (r_state == ST_REQ) || (r_state == ST_WAIT);

  // Only the registered select can steer ready/data into the bridge.
  always_comb begin
    w_rdy   = 1'b0;
    w_sdata = '0;
    s_cs    = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_rdy   = s_ready[i];
        w_sdata = s_rdata[32*i +: 32];
        s_cs[i] = w_act;
      end
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_w(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  assign w_to = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if (w_act) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  localparam int unsigned TMO_UNUSED = TIMEOUT;

  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_hit && w_strobe) begin
            r_sel   <= w_sel;
            r_addr  <= w_saddr;
            r_wdata <= io_wdata;
            r_wmask <= io_wmask;
            r_wr    <= io_wr_strobe;
            r_err   <= w_unmapped;
            r_rdata <= (w_unmapped && !io_wr_strobe) ? ERR_RDATA : '0;
            r_state <= w_unmapped ? ST_RESP : ST_REQ;
          end
        end
        ST_REQ, ST_WAIT: begin
          // Ready beats a simultaneous timeout.
          if (w_rdy) begin
            r_rdata <= r_wr ? '0 : w_sdata;
            r_state <= ST_RESP;
          end else if (w_to) begin
            r_err   <= 1'b1;
            r_rdata <= r_wr ? '0 : ERR_RDATA;
            r_state <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_busy  = (r_state != ST_IDLE);
  assign io_done  = (r_state == ST_RESP);
  assign io_err   = io_done & r_err;
  assign io_rdata = io_done ? r_rdata : '0;

  assign s_rd    = w_act & ~r_wr;
  assign s_wr    = w_act & r_wr;
  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;
  assign s_wmask = r_wmask;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Self-checking bench for mmio_bus_bridge with a behavioural slave model.
// Timeout scenarios run only when BRIDGE_TIMEOUT_EN is defined.
module tb_mmio_bus_bridge;

  localparam int N   = 4;
  localparam int SW  = 4;
  localparam int AW  = 21;
  localparam int TMO = 8;
  localparam int NEVER = 100000;

  logic            clk = 1'b0;
  logic            resetn;
  logic [31:0]     io_addr;
  logic            io_rd_strobe;
  logic            io_wr_strobe;
  logic [31:0]     io_wdata;
  logic [3:0]      io_wmask;
  logic [31:0]     io_rdata;
  logic            io_done;
  logic            io_busy;
  logic            io_err;
  logic [N-1:0]    s_cs;
  logic            s_rd;
  logic            s_wr;
  logic [AW-1:0]   s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wmask;
  logic [N*32-1:0] s_rdata;
  logic [N-1:0]    s_ready;
  logic [N-1:0]    noise;

  int k_lat[N];
  int cnt[N];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_bus_bridge #(
    .N_SLV   (N),
    .SEL_W   (SW),
    .SLV_AW  (AW),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .io_addr      (io_addr),
    .io_rd_strobe (io_rd_strobe),
    .io_wr_strobe (io_wr_strobe),
    .io_wdata     (io_wdata),
    .io_wmask     (io_wmask),
    .io_rdata     (io_rdata),
    .io_done      (io_done),
    .io_busy      (io_busy),
    .io_err       (io_err),
    .s_cs         (s_cs),
    .s_rd         (s_rd),
    .s_wr         (s_wr),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_wmask      (s_wmask),
    .s_rdata      (s_rdata),
    .s_ready      (s_ready)
  );

  // Slave model: selected slave answers after k_lat wait cycles;
  // unselected slaves drive random ready noise.
  always_comb begin
    for (int i = 0; i < N; i++)
      s_ready[i] = s_cs[i] ? (cnt[i] == k_lat[i]) : noise[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      cnt[i] <= s_cs[i] ? cnt[i] + 1 : 0;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " done"},  64'(io_done),  0);
    chk({tag, " busy"},  64'(io_busy),  0);
    chk({tag, " err"},   64'(io_err),   0);
    chk({tag, " cs"},    64'(s_cs),     0);
    chk({tag, " rd/wr"}, 64'({s_rd, s_wr}), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk_quiet(tag);
    chk({tag, " rdata"}, 64'(io_rdata), 0);
    chk({tag, " saddr"}, 64'(s_addr),   0);
    chk({tag, " swdata"}, 64'(s_wdata), 0);
    chk({tag, " swmask"}, 64'(s_wmask), 0);
  endtask

  // One CPU access; expected behaviour computed from the bridge rules.
  task automatic txn(input string tag, input logic [31:0] addr,
                     input bit rd, input bit wr,
                     input logic [31:0] wd, input logic [3:0] wm,
                     input int k, input logic [31:0] sdata,
                     input bit poke);
    bit hit, unm, to, err;
    int sel, lat;
    logic [31:0] exp_rd;
    logic [N-1:0] ecs;
    logic [AW-1:0] ea;
    hit = (addr[31:24] == 8'hC0);
    sel = int'(addr[23:20]);
    unm = (sel >= N);
    ea  = addr[22:2];
    to  = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    to = (k >= TMO);
`endif
    for (int i = 0; i < N; i++) begin
      k_lat[i] = NEVER;
      noise[i] = 1'($urandom);
      s_rdata[32*i +: 32] = $urandom;
    end
    ecs = '0;
    if (!unm) begin
      k_lat[sel] = k;
      s_rdata[32*sel +: 32] = sdata;
      ecs[sel] = 1'b1;
    end
    lat = unm ? 1 : (to ? 1 + TMO : 2 + k);
    err = unm || to;
    exp_rd = wr ? 32'h0 : (err ? 32'hDEAD_BEEF : sdata);

    @(negedge clk);
    io_addr = addr;
    io_rd_strobe = rd;
    io_wr_strobe = wr;
    io_wdata = wd;
    io_wmask = wm;
    @(negedge clk);
    io_rd_strobe = 1'b0;
    io_wr_strobe = 1'b0;

    if (!hit || !(rd || wr)) begin
      for (int n = 1; n <= 3; n++) begin
        if (n > 1) @(negedge clk);
        chk_quiet({tag, " miss"});
      end
      return;
    end

    for (int n = 1; n <= lat; n++) begin
      if (n > 1) @(negedge clk);
      chk({tag, " done"}, 64'(io_done), 64'(n == lat));
      chk({tag, " busy"}, 64'(io_busy), 1);
      if (n < lat) begin
        chk({tag, " cs"},     64'(s_cs),    64'(ecs));
        chk({tag, " wr"},     64'(s_wr),    64'(wr));
        chk({tag, " rd"},     64'(s_rd),    64'(!wr));
        chk({tag, " saddr"},  64'(s_addr),  64'(ea));
        chk({tag, " swdata"}, 64'(s_wdata), 64'(wd));
        chk({tag, " swmask"}, 64'(s_wmask), 64'(wm));
      end else begin
        chk({tag, " err"},   64'(io_err),   64'(err));
        chk({tag, " rdata"}, 64'(io_rdata), 64'(exp_rd));
        chk({tag, " cs off"}, 64'(s_cs), 0);
      end
      if (poke && n == 2) begin
        io_addr = 32'hC000_0000;
        io_rd_strobe = 1'b1;
      end
      if (poke && n == 3) io_rd_strobe = 1'b0;
    end
    io_rd_strobe = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk_quiet({tag, " after"});
    end
  endtask

  initial begin
    resetn = 1'b0;
    io_addr = '0;
    io_rd_strobe = 1'b0;
    io_wr_strobe = 1'b0;
    io_wdata = '0;
    io_wmask = '0;
    noise = '0;
    s_rdata = '0;
    for (int i = 0; i < N; i++) k_lat[i] = NEVER;

    @(negedge clk);
    @(negedge clk);
    chk_reset("reset");
    resetn = 1'b1;

    txn("rd0", 32'hC000_0010, 1, 0, 32'h0, 4'h0, 0, 32'h1234_5678, 0);
    txn("wr1", 32'hC010_0008, 0, 1, 32'hA5A5_0F0F, 4'b0011, 3,
        32'h0, 0);
    txn("unm_rd", 32'hC090_0000, 1, 0, 32'h0, 4'h0, 0, 32'h0, 0);
    txn("unm_wr", 32'hC040_0004, 0, 1, 32'h55, 4'hF, 0, 32'h0, 0);
    txn("miss", 32'h0000_0040, 1, 0, 32'h0, 4'h0, 0, 32'h0, 0);
    txn("rdwr", 32'hC020_0100, 1, 1, 32'hCAFE_F00D, 4'hF, 1,
        32'h7777_7777, 0);
    txn("busy", 32'hC030_0FFC, 1, 0, 32'h0, 4'h0, 4,
        32'h0BAD_CAFE, 1);
`ifdef BRIDGE_TIMEOUT_EN
    txn("tmo_rd", 32'hC010_0040, 1, 0, 32'h0, 4'h0, NEVER,
        32'h1111_1111, 0);
    txn("tmo_wr", 32'hC000_0040, 0, 1, 32'h1, 4'h1, NEVER,
        32'h0, 0);
    txn("tmo_edge", 32'hC020_0040, 1, 0, 32'h0, 4'h0, TMO - 1,
        32'h2222_2222, 0);
    txn("tmo_late", 32'hC030_0040, 1, 0, 32'h0, 4'h0, TMO,
        32'h3333_3333, 0);
`endif

    // Reset while the bridge is waiting on slave 2.
    for (int i = 0; i < N; i++) k_lat[i] = NEVER;
    k_lat[2] = 6;
    noise = '0;
    @(negedge clk);
    io_addr = 32'hC020_0020;
    io_rd_strobe = 1'b1;
    @(negedge clk);
    io_rd_strobe = 1'b0;
    @(negedge clk);
    chk("rst_wait cs", 64'(s_cs), 64'(4'b0100));
    resetn = 1'b0;
    @(negedge clk);
    chk_reset("rst_mid");
    resetn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk_quiet("rst_after");
    end
    txn("rst_rd", 32'hC000_0024, 1, 0, 32'h0, 4'h0, 1,
        32'h600D_600D, 0);

    for (int t = 0; t < 25; t++) begin
      logic [31:0] a;
      logic [3:0] sel;
      int op;
      sel = 4'($urandom_range(0, 5));
      op  = $urandom_range(0, 2);
      a   = {8'hC0, sel, 18'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) a[31:24] = 8'h40;
      txn("rnd", a, op != 1, op != 0, $urandom, 4'($urandom),
          $urandom_range(0, 4), $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
